// File: rtl/cr_xp10_decomp_tlv_passthru_pkg.sv
// Shared TLV type codes, control-bit positions and default beat layout for the
// XP10 decompressor stub pass-through.
package cr_xp10_decomp_tlv_passthru_pkg;

    typedef enum logic [7:0] {
        TLV_RQT  = 8'h00,
        TLV_CMD  = 8'h01,
        TLV_KEY  = 8'h02,
        TLV_PHD  = 8'h03,
        TLV_PFD  = 8'h04,
        TLV_DATA = 8'h05,
        TLV_FTR  = 8'h08,
        TLV_FRMD = 8'h0b
    } tlv_types_e;

    localparam int unsigned TLV_SOT_BIT = 0;
    localparam int unsigned TLV_EOT_BIT = 1;

    localparam int unsigned WIDX_W = 5;
    localparam logic [WIDX_W-1:0] WIDX_MAX = '1;

    localparam int unsigned PT_DATA_W  = 64;
    localparam int unsigned PT_STRB_W  = PT_DATA_W / 8;
    localparam int unsigned PT_TUSER_W = 8;
    localparam int unsigned PT_TID_W   = 1;

    typedef struct packed {
        logic [PT_DATA_W-1:0]  data;
        logic [PT_STRB_W-1:0]  strb;
        logic [PT_TUSER_W-1:0] user;
        logic [PT_TID_W-1:0]   id;
        logic                  last;
    } tlv_pt_beat_t;

endpackage

// File: rtl/cr_xp10_decomp_tlv_passthru_if.sv
// AXI4-Stream TLV bus with master/slave views.
interface cr_xp10_decomp_tlv_passthru_if #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TID_W   = 1,
    parameter int unsigned TUSER_W = 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;
    logic [TUSER_W-1:0]    tuser;
    logic [TID_W-1:0]      tid;
    logic                  tlast;

    modport master (output tvalid, tdata, tstrb, tuser, tid, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tuser, tid, tlast, output tready);
endinterface

// File: rtl/cr_xp10_decomp_skid2.sv
// Generic 2-entry skid buffer; ready is registered and drops only when both entries are held.
module cr_xp10_decomp_skid2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;
    logic             r_rdy;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_cnt_nxt;

    always_comb begin
        w_push    = i_valid & r_rdy;
        w_pop     = (r_cnt != 2'd0) & i_ready;
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + 2'd1;
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
            r_rdy    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= w_cnt_nxt;
            r_rdy <= (w_cnt_nxt != 2'd2);
        end
    end

    assign o_ready = r_rdy;
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rptr];
endmodule

// File: rtl/cr_xp10_decomp_tlv_passthru.sv
// TLV pass-through standing in for the decomp core: tracks TLV position, patches the footer
// bytes_out field (copied from bytes_in or counted from DATA strobes) and registers via a skid.
module cr_xp10_decomp_tlv_passthru
    import cr_xp10_decomp_tlv_passthru_pkg::*;
#(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned TID_W        = 1,
    parameter int unsigned TUSER_W      = 8,
    parameter int unsigned MODE         = 0,
    parameter int unsigned FTR_WORD_IDX = 12,
    parameter int unsigned BIN_LSB      = 0,
    parameter int unsigned BOUT_LSB     = 32,
    parameter int unsigned FIELD_W      = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    cr_xp10_decomp_tlv_passthru_if.slave        ib,
    cr_xp10_decomp_tlv_passthru_if.master       ob,
    input  logic                                patch_en,
    output logic                                ftr_patched,
    output logic                                tlv_err,
    output logic                                cnt_ovf
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PC_W   = $clog2(STRB_W + 1);
    localparam int unsigned SUM_W  = ((FIELD_W > PC_W) ? FIELD_W : PC_W) + 1;
    localparam int unsigned BEAT_W = DATA_W + STRB_W + TUSER_W + TID_W + 1;
    localparam logic [FIELD_W-1:0] CNT_MAX = '1;

    logic [7:0]         r_type;
    logic [WIDX_W-1:0]  r_widx;
    logic               r_in_tlv;
    logic [FIELD_W-1:0] r_byte_cnt;
    logic               r_cnt_ovf;
    logic               r_ftr_patched;
    logic               r_tlv_err;

    logic               w_accept;
    logic               w_sot;
    logic               w_eot;
    logic [7:0]         w_type;
    logic [WIDX_W-1:0]  w_idx;
    logic               w_patch;
    logic               w_count;
    logic               w_frm_start;
    logic               w_sat;
    logic [PC_W-1:0]    w_popcnt;
    logic [SUM_W-1:0]   w_sum;
    logic [FIELD_W-1:0] w_field;
    logic [DATA_W-1:0]  w_tdata;
    logic [BEAT_W-1:0]  w_beat_in;
    logic [BEAT_W-1:0]  w_beat_out;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < STRB_W; i++) begin
            w_popcnt = w_popcnt + PC_W'(ib.tstrb[i]);
        end
    end

    always_comb begin
        w_accept = ib.tvalid & ib.tready;
        w_sot    = ib.tuser[TLV_SOT_BIT];
        w_eot    = ib.tuser[TLV_EOT_BIT];
        w_type   = w_sot ? ib.tdata[7:0] : r_type;
        w_idx    = r_widx;
        if (w_sot) begin
            w_idx = '0;
        end else if (r_widx != WIDX_MAX) begin
            w_idx = r_widx + WIDX_W'(1);
        end

        // Beats outside any TLV are forwarded but never counted or patched.
        w_patch = (w_sot | r_in_tlv) & patch_en & (w_type == TLV_FTR) &
                  (w_idx == WIDX_W'(FTR_WORD_IDX));
        w_count = (MODE == 1) & w_accept & r_in_tlv & ~w_sot & (r_type == TLV_DATA);
        w_frm_start = w_accept & w_sot & (ib.tdata[7:0] == TLV_FRMD);

        w_sum = SUM_W'(r_byte_cnt) + SUM_W'(w_popcnt);
        w_sat = (w_sum > SUM_W'(CNT_MAX));

        w_field = (MODE == 0) ? ib.tdata[BIN_LSB +: FIELD_W] : r_byte_cnt;
        w_tdata = ib.tdata;
        if (w_patch) begin
            w_tdata[BOUT_LSB +: FIELD_W] = w_field;
        end
        w_beat_in = {w_tdata, ib.tstrb, ib.tuser, ib.tid, ib.tlast};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_type        <= '0;
            r_widx        <= '0;
            r_in_tlv      <= 1'b0;
            r_byte_cnt    <= '0;
            r_cnt_ovf     <= 1'b0;
            r_ftr_patched <= 1'b0;
            r_tlv_err     <= 1'b0;
        end else begin
            r_ftr_patched <= w_accept & w_patch;
            r_tlv_err     <= w_accept & w_sot & r_in_tlv;
            if (w_accept) begin
                r_type <= w_type;
                r_widx <= w_idx;
                if (w_eot) begin
                    r_in_tlv <= 1'b0;
                end else if (w_sot) begin
                    r_in_tlv <= 1'b1;
                end
            end
            if (w_frm_start) begin
                r_byte_cnt <= '0;
                r_cnt_ovf  <= 1'b0;
            end else if (w_count) begin
                if (w_sat) begin
                    r_byte_cnt <= CNT_MAX;
                    r_cnt_ovf  <= 1'b1;
                end else begin
                    r_byte_cnt <= w_sum[FIELD_W-1:0];
                end
            end
        end
    end

    cr_xp10_decomp_skid2 #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (ib.tvalid),
        .o_ready (ib.tready),
        .i_data  (w_beat_in),
        .o_valid (ob.tvalid),
        .i_ready (ob.tready),
        .o_data  (w_beat_out)
    );

    assign {ob.tdata, ob.tstrb, ob.tuser, ob.tid, ob.tlast} = w_beat_out;

    assign ftr_patched = r_ftr_patched;
    assign tlv_err     = r_tlv_err;
    assign cnt_ovf     = r_cnt_ovf;
endmodule

// File: tb/tb_cr_xp10_decomp_tlv_passthru.sv
// Bench: three instances (MODE=0, MODE=1, MODE=1 with FIELD_W=4) fed the same TLV vectors.
`timescale 1ns/1ps
module tb_cr_xp10_decomp_tlv_passthru;
    import cr_xp10_decomp_tlv_passthru_pkg::*;

    localparam int NI = 3;

    typedef struct {
        tlv_pt_beat_t in;
        logic         pe;
        logic [63:0]  e [NI];
        logic         flag;
        logic [NI-1:0] ovf_exp;
        int           fp_exp;
        int           te_exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv;
    tlv_pt_beat_t ib_b;
    logic        patch_en;
    logic        ob_rdy;
    logic        tog_en;
    logic        hold;
    logic        chk_rdy;

    logic [NI-1:0] w_ibrdy, w_obv, w_fp, w_te, w_ovf;
    tlv_pt_beat_t  w_ob [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned MODE_G = (g == 0) ? 0 : 1;
        localparam int unsigned FW_G   = (g == 2) ? 4 : 32;
        cr_xp10_decomp_tlv_passthru_if #(.DATA_W(64), .TID_W(1), .TUSER_W(8)) ib_if ();
        cr_xp10_decomp_tlv_passthru_if #(.DATA_W(64), .TID_W(1), .TUSER_W(8)) ob_if ();
        assign ib_if.tvalid = iv;
        assign ib_if.tdata  = ib_b.data;
        assign ib_if.tstrb  = ib_b.strb;
        assign ib_if.tuser  = ib_b.user;
        assign ib_if.tid    = ib_b.id;
        assign ib_if.tlast  = ib_b.last;
        assign ob_if.tready = ob_rdy;
        assign w_ibrdy[g]   = ib_if.tready;
        assign w_obv[g]     = ob_if.tvalid;
        assign w_ob[g]      = {ob_if.tdata, ob_if.tstrb, ob_if.tuser, ob_if.tid, ob_if.tlast};
        cr_xp10_decomp_tlv_passthru #(
            .DATA_W(64), .TID_W(1), .TUSER_W(8), .MODE(MODE_G), .FTR_WORD_IDX(12),
            .BIN_LSB(0), .BOUT_LSB(32), .FIELD_W(FW_G)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .ib          (ib_if),
            .ob          (ob_if),
            .patch_en    (patch_en),
            .ftr_patched (w_fp[g]),
            .tlv_err     (w_te[g]),
            .cnt_ovf     (w_ovf[g])
        );
    end

    int checks = 0;
    int fails  = 0;
    int n_fp [NI];
    int n_te [NI];
    int occ;
    int rdy_low;
    tlv_pt_beat_t cap0[$], cap1[$], cap2[$];
    tlv_pt_beat_t ex0[$], ex1[$], ex2[$];
    vec_t vt[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ob_tready driver: runs just after the main driver so hold/tog_en changes apply cleanly.
    initial begin
        ob_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ob_rdy = hold ? 1'b0 : (tog_en ? ~ob_rdy : 1'b1);
        end
    end

    // Monitor: captures transfers, counts pulses and models skid occupancy.
    initial begin
        occ = 0;
        rdy_low = 0;
        for (int i = 0; i < NI; i++) begin
            n_fp[i] = 0;
            n_te[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                occ = 0;
            end else begin
                if (w_obv[0] && ob_rdy) cap0.push_back(w_ob[0]);
                if (w_obv[1] && ob_rdy) cap1.push_back(w_ob[1]);
                if (w_obv[2] && ob_rdy) cap2.push_back(w_ob[2]);
                for (int i = 0; i < NI; i++) begin
                    if (w_fp[i]) n_fp[i]++;
                    if (w_te[i]) n_te[i]++;
                end
                if (chk_rdy) begin
                    chk("ib_tready_vs_occupancy", w_ibrdy[0], (occ < 2));
                    chk("ob_tvalid_vs_occupancy", w_obv[0], (occ != 0));
                    if (!w_ibrdy[0]) rdy_low++;
                end
                occ = occ + int'(iv && w_ibrdy[0]) - int'(w_obv[0] && ob_rdy);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic tlv_pt_beat_t mk(input logic [63:0] d, input logic [7:0] s,
                                        input logic sot, input logic eot, input logic id,
                                        input logic last);
        tlv_pt_beat_t b;
        b.data = d;
        b.strb = s;
        b.user = {6'b100101, eot, sot};
        b.id   = id;
        b.last = last;
        return b;
    endfunction

    function automatic void add(input tlv_pt_beat_t b, input logic pe, input logic [63:0] e0,
                                input logic [63:0] e1, input logic [63:0] e2);
        vec_t v;
        v.in = b;
        v.pe = pe;
        v.e[0] = e0;
        v.e[1] = e1;
        v.e[2] = e2;
        v.flag = 1'b0;
        v.ovf_exp = '0;
        v.fp_exp = 0;
        v.te_exp = 0;
        vt.push_back(v);
    endfunction

    function automatic void set_flag(input int idx, input logic [NI-1:0] ovf, input int fp,
                                     input int te);
        vt[idx].flag    = 1'b1;
        vt[idx].ovf_exp = ovf;
        vt[idx].fp_exp  = fp;
        vt[idx].te_exp  = te;
    endfunction

    // FRMD, DATA TLV (full 20-byte payload, or 2 bytes then cut short by the FTR SOT), 14-beat FTR.
    function automatic void build_seq(input logic pe, input logic with_err, input logic [31:0] bin);
        tlv_pt_beat_t b;
        logic [63:0]  d;
        logic [31:0]  cnt;
        logic [3:0]   c4;
        cnt = with_err ? 32'd2 : 32'd20;
        c4  = with_err ? 4'h2 : 4'hf;
        b = mk({56'h11_2222_3333_4444, TLV_FRMD}, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        add(b, pe, b.data, b.data, b.data);
        b = mk({56'hd0_d0d0_d0d0_d0d0, TLV_DATA}, 8'hff, 1'b1, 1'b0, 1'b0, 1'b0);
        add(b, pe, b.data, b.data, b.data);
        if (with_err) begin
            b = mk(64'hd1d1_d1d1_d1d1_d1d1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
            add(b, pe, b.data, b.data, b.data);
        end else begin
            b = mk(64'hd1d1_d1d1_d1d1_d1d1, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0);
            add(b, pe, b.data, b.data, b.data);
            b = mk(64'hd2d2_d2d2_d2d2_d2d2, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0);
            add(b, pe, b.data, b.data, b.data);
            b = mk(64'hd3d3_d3d3_d3d3_d3d3, 8'h0f, 1'b0, 1'b1, 1'b0, 1'b0);
            add(b, pe, b.data, b.data, b.data);
        end
        for (int i = 0; i < 14; i++) begin
            if (i == 0) d = {56'hf7_f7f7_f7f7_f7f7, TLV_FTR};
            else if (i == 12) d = {32'haaaa_aaaa, bin};
            else d = 64'ha5a5_0000_0000_0000 | 64'(i);
            b = mk(d, 8'hff, (i == 0), (i == 13), 1'b1, (i == 13));
            if (i == 12 && pe)
                add(b, pe, {bin, bin}, {cnt, bin}, {28'haaaa_aaa, c4, bin});
            else
                add(b, pe, d, d, d);
        end
    endfunction

    task automatic send(input tlv_pt_beat_t b, input logic pe);
        int t;
        logic acc;
        t = 0;
        iv = 1'b1;
        ib_b = b;
        patch_en = pe;
        forever begin
            @(negedge clk);
            acc = w_ibrdy[0];
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 50) begin
                chk("send_timeout", 1'b1, 1'b0);
                break;
            end
        end
        iv = 1'b0;
    endtask

    task automatic cmp_q(input string nm, input tlv_pt_beat_t got[$], input tlv_pt_beat_t exp[$]);
        chk({nm, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) chk(nm, got[i], exp[i]);
        end
    endtask

    task automatic clear_caps();
        cap0.delete(); cap1.delete(); cap2.delete();
        ex0.delete(); ex1.delete(); ex2.delete();
    endtask

    initial begin
        tlv_pt_beat_t b;
        int f;
        rst_n = 1'b0;
        iv = 1'b0;
        ib_b = '0;
        patch_en = 1'b0;
        tog_en = 1'b0;
        hold = 1'b0;
        chk_rdy = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ob_tvalid", w_obv, 3'b000);
        chk("reset_ib_tready", w_ibrdy, 3'b000);
        chk("reset_pulses", {w_fp, w_te, w_ovf}, 9'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_ib_tready", w_ibrdy, 3'b111);
        chk("post_reset_ob_tvalid", w_obv, 3'b000);

        // Vector table: patched stream, unpatched stream, stream with a mid-TLV SOT.
        build_seq(1'b1, 1'b0, 32'h0000_0123);
        set_flag(vt.size() - 1, 3'b100, 1, 0);
        f = vt.size();
        build_seq(1'b0, 1'b0, 32'h0000_0777);
        set_flag(f, 3'b000, 1, 0);
        set_flag(vt.size() - 1, 3'b100, 1, 0);
        build_seq(1'b1, 1'b1, 32'h0000_0456);
        set_flag(vt.size() - 1, 3'b000, 2, 1);

        @(posedge clk);
        #1;
        clear_caps();
        for (int i = 0; i < vt.size(); i++) begin
            send(vt[i].in, vt[i].pe);
            b = vt[i].in;
            b.data = vt[i].e[0]; ex0.push_back(b);
            b.data = vt[i].e[1]; ex1.push_back(b);
            b.data = vt[i].e[2]; ex2.push_back(b);
            if (vt[i].flag) begin
                @(negedge clk);
                @(posedge clk);
                #1;
                for (int g = 0; g < NI; g++) begin
                    chk($sformatf("cnt_ovf_inst%0d_vec%0d", g, i), w_ovf[g], vt[i].ovf_exp[g]);
                    chk($sformatf("ftr_patched_cnt_inst%0d_vec%0d", g, i), n_fp[g], vt[i].fp_exp);
                    chk($sformatf("tlv_err_cnt_inst%0d_vec%0d", g, i), n_te[g], vt[i].te_exp);
                end
            end
        end
        repeat (6) @(posedge clk);
        #1;
        cmp_q("tlv_beat_mode0", cap0, ex0);
        cmp_q("tlv_beat_mode1", cap1, ex1);
        cmp_q("tlv_beat_fw4", cap2, ex2);

        // Backpressure: ob_tready toggling, 100 beats, order and ready behaviour checked.
        clear_caps();
        tog_en = 1'b1;
        chk_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            b = mk(64'hbeef_0000_0000_0000 | 64'(i), 8'hff, 1'b0, 1'b0, 1'(i), (i == 99));
            ex0.push_back(b);
            send(b, 1'b1);
        end
        repeat (6) @(posedge clk);
        #1;
        chk_rdy = 1'b0;
        tog_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cmp_q("bp_stream_inst0", cap0, ex0);
        cmp_q("bp_stream_inst1", cap1, ex0);
        cmp_q("bp_stream_inst2", cap2, ex0);
        chk("bp_ready_went_low", (rdy_low > 0), 1'b1);

        // Saturation with a held output, then reset mid-TLV.
        clear_caps();
        send(mk({56'h0, TLV_FRMD}, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
        send(mk({56'h0, TLV_DATA}, 8'hff, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        send(mk(64'h1, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        hold = 1'b1;
        send(mk(64'h2, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        @(negedge clk);
        chk("held_ob_tvalid", w_obv, 3'b111);
        chk("held_ib_tready", w_ibrdy, 3'b000);
        chk("sat_cnt_ovf", w_ovf, 3'b100);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midtlv_reset_ob_tvalid", w_obv, 3'b000);
        chk("midtlv_reset_cnt_ovf", w_ovf, 3'b000);
        chk("midtlv_reset_ib_tready", w_ibrdy, 3'b000);
        hold = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_reset_ob_tvalid", w_obv, 3'b000);
        end
        chk("after_reset_ib_tready", w_ibrdy, 3'b111);
        chk("no_partial_output", cap0.size(), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
